// File: rtl/uart_pkg.sv
// Shared constants, state encoding and packet formatters
// for the UART TX packetizer.
package uart_pkg;

  localparam int PKT_W = 40;

  localparam logic [7:0] HDR_A  = 8'h41;
  localparam logic [7:0] HDR_M  = 8'h4D;
  localparam logic [7:0] HDR_LA = 8'h61;
  localparam logic [7:0] HDR_LM = 8'h6D;
  localparam logic [7:0] HDR_R  = 8'h52;
  localparam logic [7:0] HDR_S  = 8'h53;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESENT,
    ST_WAIT_DONE
  } tx_state_t;

  function automatic logic [PKT_W-1:0] fmt_ads(
    input logic [31:0] d
  );
    return {HDR_A, d};
  endfunction

  function automatic logic [PKT_W-1:0] fmt_mpr(
    input logic [15:0] d
  );
    return {HDR_M, d, 16'h0};
  endfunction

  function automatic logic [PKT_W-1:0] fmt_reg(
    input logic       src,
    input logic [7:0] addr,
    input logic [7:0] data
  );
    return {src ? HDR_LA : HDR_LM, addr, data, 16'h0};
  endfunction

endpackage

// File: rtl/uart_tx_packetizer_if.sv
// Packet handshake towards the UART controller TX port.
// master = packetizer, slave = controller.
interface uart_tx_packetizer_if;
  import uart_pkg::*;

  logic [PKT_W-1:0] o_UART_DATA_TX;
  logic             o_UART_DATA_TX_VALID;
  logic             i_DATA_TX_READY;

  modport master (
    output o_UART_DATA_TX,
    output o_UART_DATA_TX_VALID,
    input  i_DATA_TX_READY
  );

  modport slave (
    input  o_UART_DATA_TX,
    input  o_UART_DATA_TX_VALID,
    output i_DATA_TX_READY
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush, level and full/empty flags.
// Push on full and pop on empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_packetizer.sv
// Formats sensor results into 40-bit packets, queues them
// and hands them one at a time to the UART controller.
module uart_tx_packetizer
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_CNT_W = 8
) (
  input  logic                          i_CLK,
  input  logic                          i_RSTN,
  input  logic [31:0]                   i_ADS_DATA,
  input  logic                          i_ADS_DATA_VALID,
  input  logic [15:0]                   i_MPR_DATA,
  input  logic                          i_MPR_DATA_VALID,
  input  logic [7:0]                    i_REG_ADDR,
  input  logic [7:0]                    i_REG_DATA,
  input  logic                          i_REG_SRC,
  input  logic                          i_REG_DATA_VALID,
  input  logic                          i_FLUSH,
  uart_tx_packetizer_if.master          tx,
  output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_LEVEL,
  output logic [DROP_CNT_W-1:0]         o_DROP_CNT
);

  logic [PKT_W-1:0] reg_pkt, ads_pkt, mpr_pkt;
  logic [PKT_W-1:0] push_pkt, head;
  logic reg_pend, ads_pend, mpr_pend;
  logic sel_reg, sel_ads, sel_mpr;
  logic push, pop, full, empty, hold;
  logic reg_drop, ads_drop, mpr_drop;
  logic [1:0] drop_n;
  logic [DROP_CNT_W+1:0] drop_sum;
  logic rdy;
  tx_state_t state;

  assign rdy = tx.i_DATA_TX_READY;

  always_comb begin
    sel_reg = !i_FLUSH && !full && reg_pend;
    sel_ads = !i_FLUSH && !full && !reg_pend && ads_pend;
    sel_mpr = !i_FLUSH && !full && !reg_pend
              && !ads_pend && mpr_pend;
    push = sel_reg || sel_ads || sel_mpr;
    push_pkt = '0;
    unique case (1'b1)
      sel_reg: push_pkt = reg_pkt;
      sel_ads: push_pkt = ads_pkt;
      sel_mpr: push_pkt = mpr_pkt;
      default: push_pkt = '0;
    endcase
  end

  // a strobe landing on a flag that is being pushed is not a drop
  always_comb begin
    reg_drop = !i_FLUSH && i_REG_DATA_VALID && reg_pend && !sel_reg;
    ads_drop = !i_FLUSH && i_ADS_DATA_VALID && ads_pend && !sel_ads;
    mpr_drop = !i_FLUSH && i_MPR_DATA_VALID && mpr_pend && !sel_mpr;
    drop_n = 2'(reg_drop) + 2'(ads_drop) + 2'(mpr_drop);
    drop_sum = {2'b00, o_DROP_CNT} + (DROP_CNT_W+2)'(drop_n);
  end

  assign pop = (state == ST_PRESENT) && !rdy && !i_FLUSH;

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      reg_pend   <= 1'b0;
      ads_pend   <= 1'b0;
      mpr_pend   <= 1'b0;
      reg_pkt    <= '0;
      ads_pkt    <= '0;
      mpr_pkt    <= '0;
      o_DROP_CNT <= '0;
    end else begin
      if (|drop_sum[DROP_CNT_W+1:DROP_CNT_W]) o_DROP_CNT <= '1;
      else o_DROP_CNT <= drop_sum[DROP_CNT_W-1:0];
      if (i_FLUSH) begin
        reg_pend <= 1'b0;
        ads_pend <= 1'b0;
        mpr_pend <= 1'b0;
      end else begin
        if (i_REG_DATA_VALID) begin
          reg_pend <= 1'b1;
          reg_pkt  <= fmt_reg(i_REG_SRC, i_REG_ADDR, i_REG_DATA);
        end else if (sel_reg) reg_pend <= 1'b0;
        if (i_ADS_DATA_VALID) begin
          ads_pend <= 1'b1;
          ads_pkt  <= fmt_ads(i_ADS_DATA);
        end else if (sel_ads) ads_pend <= 1'b0;
        if (i_MPR_DATA_VALID) begin
          mpr_pend <= 1'b1;
          mpr_pkt  <= fmt_mpr(i_MPR_DATA);
        end else if (sel_mpr) mpr_pend <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_CLK),
    .rst_n (i_RSTN),
    .push  (push),
    .pop   (pop),
    .flush (i_FLUSH),
    .din   (push_pkt),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (o_FIFO_LEVEL)
  );

  // hold keeps a flushed mid-transmission controller from
  // being handed a packet before it reports done
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      state                  <= ST_IDLE;
      hold                   <= 1'b0;
      tx.o_UART_DATA_TX       <= '0;
      tx.o_UART_DATA_TX_VALID <= 1'b0;
    end else if (i_FLUSH) begin
      state                  <= ST_IDLE;
      tx.o_UART_DATA_TX_VALID <= 1'b0;
      hold <= (state == ST_WAIT_DONE)
              || (state == ST_PRESENT && !rdy)
              || (hold && !rdy);
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (hold) begin
            if (rdy) hold <= 1'b0;
          end else if (!empty && rdy) begin
            tx.o_UART_DATA_TX       <= head;
            tx.o_UART_DATA_TX_VALID <= 1'b1;
            state                  <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (!rdy) begin
            tx.o_UART_DATA_TX_VALID <= 1'b0;
            state                  <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (rdy) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
